mem_mapped_uart_tx: RTL and testbench

//  Memory-mapped 8N1 UART transmitter on the CPU data bus; a peer of the bus registers.
//  Its bit period comes from a neighbouring mem_mapped_reg whose reg_out drives baud_div.
//  CPU writes bytes to DATA_ADDR; they are queued in a small FIFO and shifted out on tx.

---
 rtl/mem_mapped_uart_tx_pkg.sv | 16 +
 rtl/mem_mapped_uart_tx_sync_fifo.sv | 47 ++++
 rtl/mem_mapped_uart_tx.sv | 114 +++++++++++
 tb/tb_mem_mapped_uart_tx.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_mapped_uart_tx_pkg.sv
// Shared constants for the memory-mapped UART transmitter: bus addresses,
// TX FSM state encodings and STATUS word bit positions.
package mem_mapped_uart_tx_pkg;
  localparam logic [15:0] UART_DATA_ADDR   = 16'hFF10;
  localparam logic [15:0] UART_STATUS_ADDR = 16'hFF11;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam int ST_EMPTY = 0;
  localparam int ST_FULL  = 1;
  localparam int ST_BUSY  = 2;
  localparam int ST_OVF   = 3;
endpackage

// File: rtl/mem_mapped_uart_tx_sync_fifo.sv
// Show-ahead synchronous FIFO: dout holds the head entry whenever !empty.
// A push while full is accepted only when a pop happens on the same edge.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);
  localparam int DEPTH = 1 << AW;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/mem_mapped_uart_tx.sv
// 8N1 UART transmitter on the CPU data bus: byte FIFO behind DATA_ADDR,
// sticky-overflow status at STATUS_ADDR, read data zero when not selected.
module mem_mapped_uart_tx
  import mem_mapped_uart_tx_pkg::*;
#(
  parameter logic [15:0] DATA_ADDR   = UART_DATA_ADDR,
  parameter logic [15:0] STATUS_ADDR = UART_STATUS_ADDR,
  parameter int          FIFO_AW     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_addr,
  input  logic        mem_wr_en,
  input  logic        mem_rd_en,
  input  logic [15:0] data_in,
  output logic [15:0] data_out,
  input  logic [15:0] baud_div,
  output logic        tx,
  output logic        busy
);
  logic [1:0]  state;
  logic [15:0] div, cnt;
  logic [7:0]  shreg;
  logic [2:0]  bit_idx;
  logic        ovf;
  logic        wr_hit, rd_stat, drop, bit_end;
  logic        fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [7:0]  fifo_dout;
  logic [15:0] status_word;

  assign wr_hit    = mem_wr_en && (mem_addr == DATA_ADDR);
  assign rd_stat   = mem_rd_en && (mem_addr == STATUS_ADDR);
  assign fifo_pop  = (state == S_IDLE) && !fifo_empty;
  assign fifo_push = wr_hit;
  // Dropped only when nothing leaves the FIFO on this edge to make room.
  assign drop      = wr_hit && fifo_full && !fifo_pop;
  assign bit_end   = (cnt == div);

  sync_fifo #(.WIDTH(8), .AW(FIFO_AW)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (data_in[7:0]),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  always_comb begin
    status_word           = '0;
    status_word[ST_EMPTY] = fifo_empty;
    status_word[ST_FULL]  = fifo_full;
    status_word[ST_BUSY]  = busy;
    status_word[ST_OVF]   = ovf;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out <= '0;
      ovf      <= 1'b0;
    end else begin
      data_out <= rd_stat ? status_word : '0;
      if (drop)         ovf <= 1'b1;
      else if (rd_stat) ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div     <= '0;
      cnt     <= '0;
      shreg   <= '0;
      bit_idx <= '0;
      tx      <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (fifo_pop) begin
          shreg <= fifo_dout;
          div   <= baud_div;
          cnt   <= '0;
          tx    <= 1'b0;
          busy  <= 1'b1;
          state <= S_START;
        end
        S_START: if (bit_end) begin
          cnt     <= '0;
          bit_idx <= '0;
          tx      <= shreg[0];
          state   <= S_DATA;
        end else cnt <= cnt + 1'b1;
        S_DATA: if (bit_end) begin
          cnt <= '0;
          if (bit_idx == 3'd7) begin
            tx    <= 1'b1;
            state <= S_STOP;
          end else begin
            bit_idx <= bit_idx + 1'b1;
            shreg   <= shreg >> 1;
            tx      <= shreg[1];
          end
        end else cnt <= cnt + 1'b1;
        S_STOP: if (bit_end) begin
          cnt   <= '0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end else cnt <= cnt + 1'b1;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_mapped_uart_tx.sv
// Scoreboard bench: stimulus queues expected frames and read data; independent
// monitors decode the serial line and the bus read port and compare.
module tb_mem_mapped_uart_tx;
  localparam logic [15:0] DATA = 16'hFF10;
  localparam logic [15:0] STAT = 16'hFF11;

  logic        clk, rst_n;
  logic [15:0] mem_addr, data_in, data_out, baud_div;
  logic        mem_wr_en, mem_rd_en, tx, busy;

  mem_mapped_uart_tx dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_wr_en(mem_wr_en),
    .mem_rd_en(mem_rd_en), .data_in(data_in), .data_out(data_out),
    .baud_div(baud_div), .tx(tx), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [7:0] b; int div; } frame_t;
  frame_t      fq[$];
  logic [15:0] rq[$];
  longint      fstart[$];
  longint      cyc = 0;
  int          checks = 0, errors = 0;
  bit          mon_active = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Read-port monitor: every cycle data_out is either the queued read response or zero.
  logic rd_sampled;
  initial forever begin
    @(posedge clk);
    rd_sampled = mem_rd_en;
    #1;
    if (rst_n !== 1'b1) continue;
    if (rd_sampled) begin
      if (rq.size() == 0) chk("rd_unexpected", 32'(data_out), 32'hDEAD);
      else chk("rd_data", 32'(data_out), 32'(rq.pop_front()));
    end else chk("data_out_idle", 32'(data_out), 32'h0);
  end

  // Serial-line monitor: each start bit consumes one expected frame.
  frame_t      mf;
  logic [9:0]  mbits;
  bit          aborted, ok;
  int          wt;
  initial forever begin
    @(posedge clk); #1;
    if (rst_n === 1'b1 && tx === 1'b0) begin
      mon_active = 1;
      fstart.push_back(cyc);
      if (fq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_frame start at cycle %0d, no frame expected", cyc);
        wt = 0;
        while (tx === 1'b0 && wt < 2000) begin @(posedge clk); #1; wt++; end
      end else begin
        mf = fq.pop_front();
        mbits = {1'b1, mf.b, 1'b0};
        aborted = 0;
        for (int i = 0; i < 10 && !aborted; i++) begin
          ok = 1;
          for (int j = 0; j <= mf.div; j++) begin
            if (i != 0 || j != 0) begin @(posedge clk); #1; end
            if (rst_n !== 1'b1) begin aborted = 1; break; end
            if (tx !== mbits[i] || busy !== 1'b1) ok = 0;
          end
          if (!aborted) begin
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL frame_bit byte=%h bit=%0d actual tx/busy wrong, required tx=%b busy=1 for %0d clks",
                       mf.b, i, mbits[i], mf.div + 1);
            end
          end
        end
        if (!aborted) begin
          @(posedge clk); #1;
          if (rst_n === 1'b1) chk("idle_gap_busy_tx", {30'b0, busy, tx}, 32'h1);
        end
      end
      mon_active = 0;
    end
  end

  task automatic drive(bit wr, bit rd, logic [15:0] a, logic [15:0] d);
    @(negedge clk);
    mem_wr_en = wr; mem_rd_en = rd; mem_addr = a; data_in = d;
  endtask
  task automatic wr(logic [15:0] a, logic [15:0] d); drive(1, 0, a, d); endtask
  task automatic rd(logic [15:0] a, logic [15:0] exp); rq.push_back(exp); drive(0, 1, a, 16'h0); endtask
  task automatic idle(int n); repeat (n) drive(0, 0, 16'h0000, 16'h0); endtask
  task automatic push_frame(logic [7:0] b, int div);
    frame_t f; f.b = b; f.div = div; fq.push_back(f);
  endtask
  task automatic drain();
    int t = 0;
    idle(2);
    while (!(fq.size() == 0 && !mon_active && busy === 1'b0) && t < 20000) begin idle(1); t++; end
    if (t >= 20000) chk("drain_timeout", 32'(fq.size()), 32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int k, n0, cnt;
    logic [7:0] b;
    logic [15:0] a, exp;
    rst_n = 0; mem_wr_en = 0; mem_rd_en = 0; mem_addr = 0; data_in = 0; baud_div = 0;
    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'h1);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_data_out", 32'(data_out), 32'h0);
    rst_n = 1;

    // Status after reset, and reads that must return zero
    rd(STAT, 16'h0001);
    idle(1);
    chk("post_reset_tx_busy", {30'b0, busy, tx}, 32'h1);
    rd(16'h0000, 16'h0);
    rd(DATA, 16'h0);
    idle(3);

    // Single frame at baud_div=3
    baud_div = 16'd3;
    push_frame(8'hA5, 3);
    wr(DATA, 16'h12A5);
    drain();

    // Overflow: six back-to-back writes at baud_div=9
    baud_div = 16'd9;
    fstart.delete();
    for (int i = 1; i <= 6; i++) begin
      if (i <= 5) push_frame(8'(i), 9);
      wr(DATA, 16'(i));
    end
    rd(STAT, 16'h000E);
    rd(STAT, 16'h0006);
    drain();
    chk("b2b_frame_count", 32'(fstart.size()), 32'd5);
    for (int i = 0; i + 1 < fstart.size(); i++)
      chk("b2b_start_spacing", 32'(fstart[i+1] - fstart[i]), 32'd101);

    // baud_div change mid-frame applies to the next frame only
    baud_div = 16'd3;
    push_frame(8'h5A, 3);
    push_frame(8'hC3, 7);
    wr(DATA, 16'h005A);
    wr(DATA, 16'h00C3);
    idle(10);
    baud_div = 16'd7;
    drain();

    // Writes to STATUS are ignored
    wr(STAT, 16'h00FF);
    rd(STAT, 16'h0001);
    idle(40);

    // Reset mid-DATA with three bytes queued
    baud_div = 16'd9;
    for (int i = 0; i < 4; i++) begin
      push_frame(8'hF0 + 8'(i), 9);
      wr(DATA, 16'h00F0 + 16'(i));
    end
    idle(30);
    @(negedge clk);
    rst_n = 0;
    fq.delete();
    #1;
    chk("async_reset_tx", 32'(tx), 32'h1);
    chk("async_reset_busy", 32'(busy), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1;
    rd(STAT, 16'h0001);
    idle(300);

    // Randomized bursts checked against the queue-occupancy rule
    for (int it = 0; it < 25; it++) begin
      baud_div = 16'($urandom_range(0, 4));
      k = $urandom_range(1, 7);
      for (int i = 0; i < k; i++) begin
        b = 8'($urandom);
        if (i < 5) push_frame(b, int'(baud_div));
        wr(DATA, {8'($urandom), b});
      end
      // First byte leaves the FIFO one edge after its write; five fit back-to-back.
      n0 = (k < 5) ? k : 5;
      cnt = n0 - 1;
      if (k == 1) exp = 16'h0000;
      else exp = {12'b0, k > 5, 1'b1, cnt == 4, cnt == 0};
      rd(STAT, exp);
      drain();
      a = 16'($urandom);
      if (a == DATA) a = 16'h0000;
      if ($urandom_range(0, 1) == 1) wr(a, 16'($urandom));
      rd(a, (a == STAT) ? 16'h0001 : 16'h0000);
      rd(STAT, 16'h0001);
      idle(3);
    end

    idle(20);
    chk("frames_outstanding", 32'(fq.size()), 32'h0);
    chk("reads_outstanding", 32'(rq.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
